// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared VeriRisc definitions used by the sequencer, the ALU and the datapath.
//   NPHASE   : phases per instruction cycle (fixed at 8)
//   PW       : phase counter width
//   opcode_e : 3-bit instruction opcodes
//   phase_e  : names of the eight instruction-cycle phases
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int NPHASE = 8;
  localparam int PW     = $clog2(NPHASE);

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read a memory operand and write the result to the accumulator.
  function automatic logic is_aluop(opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// Wrapping instruction-phase counter with asynchronous clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear to 0
//   ena   : advance enable
//   hold  : freeze the count regardless of ena
//   cnt   : current count
// ---------------------------------------------------------------------------
module phase_counter #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          hold,
  output logic [PW-1:0] cnt
);

  logic [PW-1:0] cnt_q, cnt_d;

  // The phase count is a power of two, so natural overflow gives the 7 -> 0 wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (ena && !hold) begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// VeriRisc control sequencer: steps the 8-phase instruction cycle, decodes the
// IR opcode into datapath strobes and latches the halted state.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : phase advance enable (no effect once halted)
//   opcode     : IR opcode
//   a_is_zero  : ALU zero flag, used only by SKZ in phase 6
//   phase      : current phase 0..7
//   sel        : address mux, 1 = PC, 0 = IR operand
//   rd, wr     : memory read / write
//   ld_ir      : load instruction register
//   inc_pc     : increment PC
//   ld_pc      : load PC (jump)
//   ld_ac      : load accumulator
//   data_e     : accumulator drives data bus
//   halt       : CPU halted
// The NPHASE parameter must stay at 8; the decode below names all eight phases.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int NPHASE = 8,
  parameter int PW     = $clog2(NPHASE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [2:0]    opcode,
  input  logic          a_is_zero,
  output logic [PW-1:0] phase,
  output logic          sel,
  output logic          rd,
  output logic          ld_ir,
  output logic          inc_pc,
  output logic          ld_pc,
  output logic          ld_ac,
  output logic          wr,
  output logic          data_e,
  output logic          halt
);

  import cpu_pkg::*;

  logic    halted_q, halted_d;
  logic    aluop;
  opcode_e op;
  phase_e  ph;

  // Halted freezes the counter; the HLT-ending edge of phase 4 still advances
  // it, so the frozen phase is 5.
  phase_counter #(.PW(PW)) u_phase_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .hold  (halted_q),
    .cnt   (phase)
  );

  assign op    = opcode_e'(opcode);
  assign ph    = phase_e'(phase);
  assign aluop = is_aluop(op);

  // Sticky: only reset clears it.
  always_comb begin
    halted_d = halted_q;
    if (ena && (ph == OP_ADDR) && (op == HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Zero-latency strobe decode of the current phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (ph)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op == HLT);
        end
        OP_FETCH:   rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (op == SKZ) && a_is_zero;
          ld_pc  = (op == JMP);
          data_e = (op == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (op == JMP);
          wr     = (op == STO);
          data_e = (op == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Strobes are compared as one 9-bit vector
// {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       a_is_zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [8:0] strobes;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .opcode    (opcode),
    .a_is_zero (a_is_zero),
    .phase     (phase),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .data_e    (data_e),
    .halt      (halt)
  );

  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  localparam logic [8:0] S_RESET  = 9'b100000000;
  localparam logic [8:0] S_HALTED = 9'b000000001;
  localparam logic [8:0] S_HLT_P4 = 9'b000100001;

  // Hand-written expected strobes per phase: ADD, SKZ z=1, SKZ z=0, STO, JMP.
  logic [8:0] tbl [5][8] = '{
    '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
      9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000},
    '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
      9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000},
    '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
      9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000},
    '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
      9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110},
    '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
      9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle on the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full instruction cycle starting at phase 0.
  task automatic run_cycle(input int t, input logic [2:0] op, input logic z, input string name);
    opcode    = op;
    a_is_zero = z;
    for (int p = 0; p < 8; p++) begin
      check($sformatf("%s ph%0d phase", name, p), 32'(phase), 32'(p));
      check($sformatf("%s ph%0d strobes", name, p), 32'(strobes), 32'(tbl[t][p]));
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    opcode    = 3'(ADD);
    a_is_zero = 1'b0;

    #2;
    check("reset phase", 32'(phase), 32'd0);
    check("reset strobes", 32'(strobes), 32'(S_RESET));
    @(negedge clk);
    rst_n = 1'b1;

    run_cycle(0, 3'(ADD), 1'b0, "add0");
    run_cycle(0, 3'(ADD), 1'b1, "add1");
    run_cycle(1, 3'(SKZ), 1'b1, "skz_z1");
    run_cycle(2, 3'(SKZ), 1'b0, "skz_z0");
    run_cycle(3, 3'(STO), 1'b1, "sto");
    run_cycle(4, 3'(JMP), 1'b0, "jmp");

    // HLT: halt shown in phase 4, then frozen at phase 5 regardless of ena.
    opcode = 3'(HLT);
    for (int p = 0; p < 5; p++) begin
      check($sformatf("hlt ph%0d phase", p), 32'(phase), 32'(p));
      check($sformatf("hlt ph%0d strobes", p), 32'(strobes),
            32'((p < 4) ? tbl[0][p] : S_HLT_P4));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      ena = k[0];
      check($sformatf("halted %0d phase", k), 32'(phase), 32'd5);
      check($sformatf("halted %0d strobes", k), 32'(strobes), 32'(S_HALTED));
      step();
    end
    rst_n = 1'b0;
    #1;
    check("halt clear phase", 32'(phase), 32'd0);
    check("halt clear strobes", 32'(strobes), 32'(S_RESET));
    @(negedge clk);
    rst_n  = 1'b1;
    ena    = 1'b1;
    opcode = 3'(ADD);

    // ena pattern 1,0,0,1 starting from phase 2.
    step();
    step();
    check("ena start phase", 32'(phase), 32'd2);
    ena = 1'b1;
    step();
    check("ena adv phase", 32'(phase), 32'd3);
    ena = 1'b0;
    step();
    check("ena hold1 phase", 32'(phase), 32'd3);
    check("ena hold1 ld_ir", 32'(ld_ir), 32'd1);
    step();
    check("ena hold2 phase", 32'(phase), 32'd3);
    check("ena hold2 ld_ir", 32'(ld_ir), 32'd1);
    ena = 1'b1;
    step();
    check("ena resume phase", 32'(phase), 32'd4);

    // HLT in phase 4 with ena=0: shown but not latched.
    opcode = 3'(HLT);
    ena    = 1'b0;
    #1;
    check("hlt noena strobes", 32'(strobes), 32'(S_HLT_P4));
    step();
    check("hlt noena phase", 32'(phase), 32'd4);
    opcode = 3'(ADD);
    ena    = 1'b1;
    step();
    check("hlt noena ph5 phase", 32'(phase), 32'd5);
    check("hlt noena ph5 strobes", 32'(strobes), 32'(tbl[0][5]));

    // Async reset mid-phase 6 with JMP.
    opcode = 3'(JMP);
    step();
    check("jmp ph6 ld_pc", 32'(ld_pc), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst phase", 32'(phase), 32'd0);
    check("async rst ld_pc", 32'(ld_pc), 32'd0);
    check("async rst strobes", 32'(strobes), 32'(S_RESET));
    @(negedge clk);
    rst_n = 1'b1;
    check("post rst phase", 32'(phase), 32'd0);
    step();
    check("post rst first inc", 32'(phase), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
